// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the arm program sequencer: FSM state encoding,
// program-table entry layout and field widths, and the dwell tick divider
// default.
//
// Coordinate format: the a/b fields of an entry (x/y or xita1/xita2) are
// signed Q16.16 fixed point. 16 integer bits and 16 fractional bits in a
// 32-bit two's complement word. The sequencer never does arithmetic on them.
// It only routes them to the arm model.
// -----------------------------------------------------------------------------
package arm_pkg;

  localparam int MODE_W   = 1;
  localparam int CATCH_W  = 1;
  localparam int DWELL_W  = 16;
  localparam int COORD_W  = 32;   // Q16.16
  localparam int STEP_W   = 3;

  // One dwell tick is 1 ms with a 50 MHz clock.
  localparam int TICK_DIV_DEFAULT = 50_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DWELL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // mode: 0 = Cartesian (a=x, b=y), 1 = joint angles (a=xita1, b=xita2).
  typedef struct packed {
    logic [MODE_W-1:0]  mode;
    logic [CATCH_W-1:0] ctch;
    logic [DWELL_W-1:0] dwell;
    logic [COORD_W-1:0] a;
    logic [COORD_W-1:0] b;
  } entry_t;

  // Prescaler width. Keeps at least one bit so TICK_DIV=1 still elaborates.
  function automatic int prescaler_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/arm_tick_gen.sv
// -----------------------------------------------------------------------------
// arm_tick_gen
// Dwell prescaler. It counts 0..TICK_DIV-1 while enabled and then wraps.
// 'tick' is high during the cycle in which the count wraps.
//
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of the prescaler (has priority over en)
//   en         : count enable
//   tick       : wrap indication (combinational from the count and en)
// -----------------------------------------------------------------------------
module arm_tick_gen
  import arm_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = prescaler_width(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (en) begin
      presc <= (presc == LAST) ? '0 : presc + PW'(1);
    end
  end

  assign tick = en && (presc == LAST);

endmodule

// File: rtl/arm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// arm_seq_ctrl
// Program sequencer for a two-link arm model. It steps through a table of
// targets. Each target is either a Cartesian (x,y) point or a joint-angle
// pair. The gripper state is applied with the target, and the sequencer then
// dwells for a programmable number of ticks.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, stop                run control (stop has priority)
//   loop, last_step            program wrap and final index (sampled live)
//   wr_en/wr_addr/wr_mode/wr_catch/wr_dwell/wr_a/wr_b
//                              table write port (ignored while busy)
//   x, y                       Cartesian target (Q16.16)
//   set_xita1, set_xita2       joint-angle target (Q16.16)
//   en1, en2                   Cartesian / angle mode enables
//   catch                      gripper command
//   busy, done, step           run status, completion pulse, active index
// -----------------------------------------------------------------------------
module arm_seq_ctrl
  import arm_pkg::*;
#(
  parameter int NSTEP    = 8,
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                loop,
  input  logic [STEP_W-1:0]   last_step,
  input  logic                wr_en,
  input  logic [STEP_W-1:0]   wr_addr,
  input  logic                wr_mode,
  input  logic                wr_catch,
  input  logic [DWELL_W-1:0]  wr_dwell,
  input  logic [COORD_W-1:0]  wr_a,
  input  logic [COORD_W-1:0]  wr_b,
  output logic [COORD_W-1:0]  x,
  output logic [COORD_W-1:0]  y,
  output logic [COORD_W-1:0]  set_xita1,
  output logic [COORD_W-1:0]  set_xita2,
  output logic                en1,
  output logic                en2,
  output logic                catch,
  output logic                busy,
  output logic                done,
  output logic [STEP_W-1:0]   step
);

  state_t state, next_state;

  entry_t             table_q [NSTEP];
  entry_t             cur;
  logic [DWELL_W-1:0] tick_cnt;
  logic               tick;
  logic               dwell_exit;
  logic               step_advance;
  logic               step_wrap;

  // ---------------------------------------------------------------------------
  // Program table. Writes are accepted only while idle. Because the table is
  // first read in LOAD, a write in the same cycle as start reaches step 0.
  // ---------------------------------------------------------------------------
  // NOTE: the table is a small flop array and is reset explicitly, so that
  // after reset it is defined as all zeros. A RAM macro would not allow this.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSTEP; i++) table_q[i] <= '0;
    end else if (wr_en && !busy) begin
      table_q[wr_addr] <= '{mode: wr_mode, ctch: wr_catch, dwell: wr_dwell,
                            a: wr_a, b: wr_b};
    end
  end

  assign cur = table_q[step];

  // ---------------------------------------------------------------------------
  // Dwell timing
  // ---------------------------------------------------------------------------
  arm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ST_LOAD),
    .en    (state == ST_DWELL),
    .tick  (tick)
  );

  // The exit test comes before the increment. A dwell of N therefore spans
  // N*TICK_DIV+1 cycles, and a dwell of 0 spans exactly one cycle.
  assign dwell_exit   = (state == ST_DWELL) && (tick_cnt == cur.dwell);
  assign step_advance = step < last_step;
  assign step_wrap    = (step == last_step) && loop;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state gets its default before the case statement, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    if (stop) begin
      next_state = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  if (start) next_state = ST_LOAD;
        ST_LOAD:  next_state = ST_DWELL;
        ST_DWELL: if (dwell_exit)
                    next_state = (step_advance || step_wrap) ? ST_LOAD : ST_DONE;
        ST_DONE:  next_state = ST_IDLE;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and step/tick bookkeeping. Targets and catch are never
  // cleared by stop or DONE. The arm keeps its last commanded pose.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      set_xita1 <= '0;
      set_xita2 <= '0;
      en1       <= 1'b0;
      en2       <= 1'b0;
      catch     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      step      <= '0;
      tick_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        en1  <= 1'b0;
        en2  <= 1'b0;
        busy <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              busy <= 1'b1;
              step <= '0;
            end
          end
          ST_LOAD: begin
            if (cur.mode == 1'b0) begin
              x   <= cur.a;
              y   <= cur.b;
              en1 <= 1'b1;
              en2 <= 1'b0;
            end else begin
              set_xita1 <= cur.a;
              set_xita2 <= cur.b;
              en1       <= 1'b0;
              en2       <= 1'b1;
            end
            catch    <= cur.ctch;
            tick_cnt <= '0;
          end
          ST_DWELL: begin
            if (dwell_exit) begin
              if (step_advance) begin
                step <= step + STEP_W'(1);
              end else if (step_wrap) begin
                step <= '0;
              end else begin
                busy <= 1'b0;
                done <= 1'b1;
              end
            end else if (tick) begin
              tick_cnt <= tick_cnt + DWELL_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
